// File: rtl/m68k_cycle_req.sv
// m68k_cycle_req: turns asynchronous 68000 bus strobes into a held,
// single-cycle-qualified request for the downstream cpu bus-interface stage,
// and answers the 68k with DTACK on acknowledge or BERR on timeout.
module m68k_cycle_req #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 1,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       asl,
    input  logic       udsl,
    input  logic       ldsl,
    input  logic       m68k_rw,
    input  logic       sel,
    input  logic       dtackl,
    output logic       dreqin,
    output logic [1:0] sizin,
    output logic       rwin,
    output logic [1:0] lane,
    output logic       dtack68l,
    output logic       berrl,
    output logic       busy
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_REQ,
        ST_HOLD
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [SYNC_STAGES-1:0] r_asSync;
    logic [SYNC_STAGES-1:0] r_udsSync;
    logic [SYNC_STAGES-1:0] r_ldsSync;
    logic [SYNC_STAGES-1:0] r_rwSync;
    logic                   r_asPrev;

    logic [SET_W-1:0] r_settleCnt;
    logic [SET_W-1:0] w_settleCntNext;
    logic [TO_W-1:0]  r_toCnt;
    logic [TO_W-1:0]  w_toCntNext;
    logic [TO_W-1:0]  w_toCntInc;
    logic             r_err;
    logic             w_errNext;
    logic             w_capture;

    logic             r_dreqin;
    logic [1:0]       r_sizin;
    logic             r_rwin;
    logic [1:0]       r_lane;
    logic             r_dtack68l;
    logic             r_berrl;
    logic             r_busy;

    logic w_asS;
    logic w_udsS;
    logic w_ldsS;
    logic w_rwS;
    logic w_asFall;

    assign w_asS      = r_asSync[SYNC_STAGES-1];
    assign w_udsS     = r_udsSync[SYNC_STAGES-1];
    assign w_ldsS     = r_ldsSync[SYNC_STAGES-1];
    assign w_rwS      = r_rwSync[SYNC_STAGES-1];
    assign w_asFall   = ~w_asS & r_asPrev;
    assign w_toCntInc = r_toCnt + TO_W'(1);

    // Bring the asynchronous 68k strobes into the sys_clk domain, idling inactive-high.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_asSync  <= '1;
            r_udsSync <= '1;
            r_ldsSync <= '1;
            r_rwSync  <= '1;
            r_asPrev  <= 1'b1;
        end else begin
            r_asSync  <= {r_asSync[SYNC_STAGES-2:0], asl};
            r_udsSync <= {r_udsSync[SYNC_STAGES-2:0], udsl};
            r_ldsSync <= {r_ldsSync[SYNC_STAGES-2:0], ldsl};
            r_rwSync  <= {r_rwSync[SYNC_STAGES-2:0], m68k_rw};
            r_asPrev  <= w_asS;
        end
    end

    // Decide the next sequencer state, counter values and when to capture the transfer attributes.
    always_comb begin
        w_nextState     = r_state;
        w_settleCntNext = r_settleCnt;
        w_toCntNext     = r_toCnt;
        w_errNext       = r_err;
        w_capture       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_asFall && sel) begin
                    w_nextState     = ST_SETTLE;
                    w_settleCntNext = '0;
                end
            end
            ST_SETTLE: begin
                if (w_asS) begin
                    w_nextState = ST_IDLE;
                end else if (r_settleCnt >= SET_W'(SETTLE - 1)) begin
                    if (!w_udsS || !w_ldsS) begin
                        w_nextState = ST_REQ;
                        w_capture   = 1'b1;
                        w_toCntNext = '0;
                        w_errNext   = 1'b0;
                    end
                end else begin
                    w_settleCntNext = r_settleCnt + SET_W'(1);
                end
            end
            ST_REQ: begin
                w_toCntNext = w_toCntInc;
                if (!dtackl) begin
                    w_nextState = ST_HOLD;
                    w_errNext   = 1'b0;
                end else if (w_toCntInc == TO_W'(TIMEOUT)) begin
                    w_nextState = ST_HOLD;
                    w_errNext   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_asS) begin
                    w_nextState = ST_IDLE;
                    w_errNext   = 1'b0;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Register state and drive every output from the next state so the 68k and downstream see clean flops.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_settleCnt <= '0;
            r_toCnt     <= '0;
            r_err       <= 1'b0;
            r_dreqin    <= 1'b0;
            r_sizin     <= 2'b00;
            r_rwin      <= 1'b1;
            r_lane      <= 2'b00;
            r_dtack68l  <= 1'b1;
            r_berrl     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_settleCnt <= w_settleCntNext;
            r_toCnt     <= w_toCntNext;
            r_err       <= w_errNext;
            r_dreqin    <= (w_nextState == ST_REQ);
            r_busy      <= (w_nextState != ST_IDLE);
            r_dtack68l  <= ~((w_nextState == ST_HOLD) && !w_errNext);
            r_berrl     <= ~((w_nextState == ST_HOLD) && w_errNext);
            if (w_capture) begin
                r_lane  <= {~w_udsS, ~w_ldsS};
                r_sizin <= (!w_udsS && !w_ldsS) ? 2'b01 : 2'b00;
                r_rwin  <= w_rwS;
            end else if ((r_state == ST_HOLD) && (w_nextState == ST_IDLE)) begin
                r_lane  <= 2'b00;
            end
        end
    end

    assign dreqin   = r_dreqin;
    assign sizin    = r_sizin;
    assign rwin     = r_rwin;
    assign lane     = r_lane;
    assign dtack68l = r_dtack68l;
    assign berrl    = r_berrl;
    assign busy     = r_busy;

endmodule
